gpio_pad_ctrl: RTL and testbench

Core-side controller for a bank of `N` GPIO pad cells. It drives every pad control input: data, output enable, input enable, pull-up/pull-down, drive strength, slew, open-drain and Schmitt selection. It samples each pad's received data, synchronises and glitch-filters it, and raises edge interrupts. It sits between the SoC register bus (a simple req/ack slave) and the pad ring.

---
 rtl/gpio_ctrl_pkg.sv | 43 ++++
 rtl/gpio_in_filter.sv | 80 ++++++++
 rtl/gpio_pad_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: shared constants for the GPIO pad controller -- register word
// addresses, PADCFG bit positions, the ISTAT/IMASK fall-bit offset, the bus
// state encoding and a helper that packs the per-pad rise/fall vectors.
package gpio_ctrl_pkg;

    // Register word addresses
    localparam logic [3:0] ADDR_DOUT   = 4'd0;
    localparam logic [3:0] ADDR_OE     = 4'd1;
    localparam logic [3:0] ADDR_IE     = 4'd2;
    localparam logic [3:0] ADDR_PU     = 4'd3;
    localparam logic [3:0] ADDR_PD     = 4'd4;
    localparam logic [3:0] ADDR_DIN    = 4'd5;
    localparam logic [3:0] ADDR_ISTAT  = 4'd6;
    localparam logic [3:0] ADDR_IMASK  = 4'd7;
    localparam logic [3:0] ADDR_PADCFG = 4'd8;
    localparam logic [3:0] ADDR_FILT   = 4'd9;

    // PADCFG field positions
    localparam int PADCFG_DS_LSB  = 0;
    localparam int PADCFG_DS_MSB  = 3;
    localparam int PADCFG_SR      = 4;
    localparam int PADCFG_CO      = 5;
    localparam int PADCFG_STE_LSB = 6;
    localparam int PADCFG_STE_MSB = 7;
    localparam int PADCFG_ODP     = 8;
    localparam int PADCFG_ODN     = 9;
    localparam int PADCFG_W       = 10;

    // Fall flags/masks live in the upper half-word of ISTAT and IMASK
    localparam int ISTAT_FALL_OFS = 16;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    // Builds the ISTAT/IMASK word from zero-extended rise and fall vectors
    function automatic logic [31:0] pack_edge_word(input logic [15:0] rise,
                                                   input logic [15:0] fall);
        return {fall, rise};
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: one pad's receive path -- 2-flop synchroniser, optional
// glitch filter (GPIO_CTRL_FILTER_EN) and din edge detector.
// Without GPIO_CTRL_FILTER_EN the filtered value is the synchroniser output.
module gpio_in_filter
    import gpio_ctrl_pkg::*;
#(
    parameter int FILT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pad_di,
    input  logic [FILT_W-1:0] i_thresh,
    output logic              o_din,
    output logic              o_rise,
    output logic              o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_din_q;
    logic w_din;

    // Two-flop synchroniser for the asynchronous pad receive data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pad_di;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_CTRL_FILTER_EN
    localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0] CNT_MAX  = {FILT_W{1'b1}};
    localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1'b1);

    logic [FILT_W-1:0] r_cnt;
    logic              r_din;

    // Glitch filter: a mismatch must persist T+1 cycles before din follows;
    // >= keeps a lowered threshold from stranding the counter above it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= CNT_ZERO;
            r_din <= 1'b0;
        end else if (r_sync2 == r_din) begin
            r_cnt <= CNT_ZERO;
        end else if (r_cnt >= i_thresh) begin
            r_din <= r_sync2;
            r_cnt <= CNT_ZERO;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_din = r_din;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^i_thresh;
    assign w_din           = r_sync2;
`endif

    // Previous din value for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_din_q <= 1'b0;
        end else begin
            r_din_q <= w_din;
        end
    end

    assign o_din  = w_din;
    assign o_rise = w_din & ~r_din_q;
    assign o_fall = ~w_din & r_din_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: core-side controller for a bank of N GPIO pads. Register
// bank behind a req/ack slave, pad controls driven straight from registers,
// filtered inputs with sticky rise/fall flags and a masked level interrupt.
// Optional feature macro: GPIO_CTRL_FILTER_EN (glitch filter + FILT register).
module gpio_pad_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int N      = 8,
    parameter int FILT_W = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [3:0]    addr_i,
    input  logic [31:0]   wdata_i,
    output logic          ack_o,
    output logic [31:0]   rdata_o,
    output logic          irq_o,
    output logic [N-1:0]  pad_do_o,
    output logic [N-1:0]  pad_oe_o,
    output logic [N-1:0]  pad_ie_o,
    output logic [N-1:0]  pad_pu_o,
    output logic [N-1:0]  pad_pd_o,
    output logic [3:0]    pad_ds_o,
    output logic          pad_sr_o,
    output logic          pad_co_o,
    output logic          pad_odp_o,
    output logic          pad_odn_o,
    output logic [1:0]    pad_ste_o,
    input  logic [N-1:0]  pad_di_i
);

    localparam logic [N-1:0] PADS_ZERO = {N{1'b0}};

    bus_state_e           r_state;
    bus_state_e           w_state_nxt;
    logic                 w_accept;
    logic                 w_wr;
    logic [3:0]           r_addr;
    logic                 r_we;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic [31:0]          w_rd_mux;
    logic [31:0]          w_filt_rd;
    logic                 r_irq;

    logic [N-1:0]         r_dout;
    logic [N-1:0]         r_oe;
    logic [N-1:0]         r_ie;
    logic [N-1:0]         r_pu;
    logic [N-1:0]         r_pd;
    logic [N-1:0]         r_istat_rise;
    logic [N-1:0]         r_istat_fall;
    logic [N-1:0]         r_imask_rise;
    logic [N-1:0]         r_imask_fall;
    logic [PADCFG_W-1:0]  r_padcfg;
    logic [FILT_W-1:0]    w_filt;

    logic [N-1:0]         w_din;
    logic [N-1:0]         w_rise;
    logic [N-1:0]         w_fall;
    logic [N-1:0]         w_w1c_rise;
    logic [N-1:0]         w_w1c_fall;
    logic                 w_unused_wdata;

    assign w_accept       = (r_state == BUS_IDLE) && req_i;
    assign w_wr           = (r_state == BUS_ACK) && r_we;
    assign w_unused_wdata = ^r_wdata;

    // Bus handshake next state: one ACK cycle per accepted request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUS_IDLE: begin
                if (req_i) begin
                    w_state_nxt = BUS_ACK;
                end else begin
                    w_state_nxt = BUS_IDLE;
                end
            end
            BUS_ACK:  w_state_nxt = BUS_IDLE;
            default:  w_state_nxt = BUS_IDLE;
        endcase
    end

    // Bus state register and capture of the accepted request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= BUS_IDLE;
            r_addr  <= 4'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= addr_i;
                r_we    <= we_i;
                r_wdata <= wdata_i;
            end
        end
    end

    // Read mux over the register map; unmapped words read 0
    always_comb begin
        w_rd_mux = 32'd0;
        case (addr_i)
            ADDR_DOUT:   w_rd_mux = 32'(r_dout);
            ADDR_OE:     w_rd_mux = 32'(r_oe);
            ADDR_IE:     w_rd_mux = 32'(r_ie);
            ADDR_PU:     w_rd_mux = 32'(r_pu);
            ADDR_PD:     w_rd_mux = 32'(r_pd);
            ADDR_DIN:    w_rd_mux = 32'(w_din);
            ADDR_ISTAT:  w_rd_mux = pack_edge_word(16'(r_istat_rise), 16'(r_istat_fall));
            ADDR_IMASK:  w_rd_mux = pack_edge_word(16'(r_imask_rise), 16'(r_imask_fall));
            ADDR_PADCFG: w_rd_mux = 32'(r_padcfg);
            ADDR_FILT:   w_rd_mux = w_filt_rd;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // Read data is loaded as the request is accepted so it is valid during ACK only
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= 32'd0;
        end else if (w_accept && !we_i) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= 32'd0;
        end
    end

    // Control register writes commit at the end of the ACK cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dout       <= PADS_ZERO;
            r_oe         <= PADS_ZERO;
            r_ie         <= PADS_ZERO;
            r_pu         <= PADS_ZERO;
            r_pd         <= PADS_ZERO;
            r_imask_rise <= PADS_ZERO;
            r_imask_fall <= PADS_ZERO;
            r_padcfg     <= {PADCFG_W{1'b0}};
        end else if (w_wr) begin
            case (r_addr)
                ADDR_DOUT:   r_dout   <= r_wdata[N-1:0];
                ADDR_OE:     r_oe     <= r_wdata[N-1:0];
                ADDR_IE:     r_ie     <= r_wdata[N-1:0];
                ADDR_PU:     r_pu     <= r_wdata[N-1:0];
                ADDR_PD:     r_pd     <= r_wdata[N-1:0];
                ADDR_IMASK: begin
                    r_imask_rise <= r_wdata[N-1:0];
                    r_imask_fall <= r_wdata[ISTAT_FALL_OFS +: N];
                end
                ADDR_PADCFG: r_padcfg <= r_wdata[PADCFG_W-1:0];
                default: begin
                end
            endcase
        end
    end

`ifdef GPIO_CTRL_FILTER_EN
    logic [FILT_W-1:0] r_filt;

    // Glitch-filter threshold register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_filt <= {FILT_W{1'b0}};
        end else if (w_wr && (r_addr == ADDR_FILT)) begin
            r_filt <= r_wdata[FILT_W-1:0];
        end
    end

    assign w_filt    = r_filt;
    assign w_filt_rd = 32'(r_filt);
`else
    assign w_filt    = {FILT_W{1'b0}};
    assign w_filt_rd = 32'd0;
`endif

    assign w_w1c_rise = (w_wr && (r_addr == ADDR_ISTAT)) ? r_wdata[N-1:0] : PADS_ZERO;
    assign w_w1c_fall = (w_wr && (r_addr == ADDR_ISTAT)) ? r_wdata[ISTAT_FALL_OFS +: N] : PADS_ZERO;

    // Sticky edge flags: a new edge overrides a same-cycle write-one-to-clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_istat_rise <= PADS_ZERO;
            r_istat_fall <= PADS_ZERO;
        end else begin
            r_istat_rise <= (r_istat_rise & ~w_w1c_rise) | w_rise;
            r_istat_fall <= (r_istat_fall & ~w_w1c_fall) | w_fall;
        end
    end

    // Registered level interrupt from the masked flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |((r_istat_rise & r_imask_rise) | (r_istat_fall & r_imask_fall));
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pad
        gpio_in_filter #(
            .FILT_W (FILT_W)
        ) u_filt (
            .i_clk    (clk_i),
            .i_rst    (rst_i),
            .i_pad_di (pad_di_i[g]),
            .i_thresh (w_filt),
            .o_din    (w_din[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    assign ack_o     = (r_state == BUS_ACK);
    assign rdata_o   = r_rdata;
    assign irq_o     = r_irq;
    assign pad_do_o  = r_dout;
    assign pad_oe_o  = r_oe;
    assign pad_ie_o  = r_ie;
    assign pad_pu_o  = r_pu;
    assign pad_pd_o  = r_pd;
    assign pad_ds_o  = r_padcfg[PADCFG_DS_MSB:PADCFG_DS_LSB];
    assign pad_sr_o  = r_padcfg[PADCFG_SR];
    assign pad_co_o  = r_padcfg[PADCFG_CO];
    assign pad_ste_o = r_padcfg[PADCFG_STE_MSB:PADCFG_STE_LSB];
    assign pad_odp_o = r_padcfg[PADCFG_ODP];
    assign pad_odn_o = r_padcfg[PADCFG_ODN];

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed bench for gpio_pad_ctrl. The pad cell is modelled
// as pad_di = pin & IE. Latency-sensitive steps adapt to GPIO_CTRL_FILTER_EN.
module tb_gpio_pad_ctrl;
    import gpio_ctrl_pkg::*;

    localparam int N = 8;
`ifdef GPIO_CTRL_FILTER_EN
    localparam int LAT = 7;   // pin change to ISTAT set with T=3: 2 sync + 4 filter + 1
`else
    localparam int LAT = 3;   // pin change to ISTAT set: 2 sync + 1
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [3:0]    addr;
    logic [31:0]   wdata;
    logic          ack;
    logic [31:0]   rdata;
    logic          irq;
    logic [N-1:0]  pad_do, pad_oe, pad_ie, pad_pu, pad_pd, pad_di;
    logic [3:0]    pad_ds;
    logic          pad_sr, pad_co, pad_odp, pad_odn;
    logic [1:0]    pad_ste;
    logic [N-1:0]  pin;
    logic [31:0]   rd_tmp;

    int n_checks = 0;
    int n_fail   = 0;

    assign pad_di = pin & pad_ie;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(.N(N), .FILT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .irq_o(irq),
        .pad_do_o(pad_do), .pad_oe_o(pad_oe), .pad_ie_o(pad_ie),
        .pad_pu_o(pad_pu), .pad_pd_o(pad_pd), .pad_ds_o(pad_ds),
        .pad_sr_o(pad_sr), .pad_co_o(pad_co), .pad_odp_o(pad_odp),
        .pad_odn_o(pad_odn), .pad_ste_o(pad_ste), .pad_di_i(pad_di)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus transaction with a bounded wait for ack; returns at ack+1 cycle
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        int waited;
        waited = 0;
        req = 1'b1; we = w; addr = a; wdata = d;
        tick(1);
        while (ack !== 1'b1 && waited < 8) begin
            tick(1);
            waited++;
        end
        check("ack_seen", 32'(ack), 32'd1);
        rd = rdata;
        req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 32'd0;
        tick(1);
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("rdata_idle", rdata, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, a, 32'd0, v);
        check(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 32'd0; pin = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_pads_a", 32'({pad_do, pad_oe, pad_ie, pad_pu}), 32'd0);
        check("rst_pads_b", 32'({pad_pd, pad_ds, pad_sr, pad_co, pad_odp, pad_odn, pad_ste, ack, irq}), 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // DOUT write: value must not appear during ack, only the cycle after
        req = 1'b1; we = 1'b1; addr = ADDR_DOUT; wdata = 32'h0000_00A5;
        tick(1);
        check("dout_ack", 32'(ack), 32'd1);
        check("dout_not_early", 32'(pad_do), 32'd0);
        req = 1'b0; we = 1'b0;
        tick(1);
        check("pad_do", 32'(pad_do), 32'h0000_00A5);
        wr(ADDR_OE, 32'h0000_00FF);
        check("pad_oe", 32'(pad_oe), 32'h0000_00FF);
        rd_chk("rd_dout", ADDR_DOUT, 32'h0000_00A5);
        rd_chk("rd_oe", ADDR_OE, 32'h0000_00FF);

        // Asynchronous reset while a write is pending, before any ack
        req = 1'b1; we = 1'b1; addr = ADDR_DOUT; wdata = 32'h0000_003C;
        #3 rst = 1'b1;
        #1;
        check("midrst_do", 32'(pad_do), 32'd0);
        check("midrst_oe", 32'(pad_oe), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        req = 1'b0; we = 1'b0;
        tick(2);
        check("midrst_ack_hold", 32'(ack), 32'd0);
        rst = 1'b0;
        tick(2);
        check("midrst_no_ack", 32'(ack), 32'd0);
        check("midrst_no_commit", 32'(pad_do), 32'd0);

        // Pad controls, PU+PD keeper passthrough, PADCFG and unmapped words
        wr(ADDR_IE, 32'h0000_0081);
        check("pad_ie", 32'(pad_ie), 32'h0000_0081);
        wr(ADDR_PU, 32'h0000_000F);
        wr(ADDR_PD, 32'h0000_000F);
        check("pu_pd_keeper", 32'({pad_pu, pad_pd}), 32'h0000_0F0F);
        wr(ADDR_PADCFG, 32'h0000_03FF);
        check("padcfg_pins", 32'({pad_ds, pad_sr, pad_co, pad_ste, pad_odp, pad_odn}), 32'h0000_03FF);
        rd_chk("rd_padcfg", ADDR_PADCFG, 32'h0000_03FF);
        wr(4'd12, 32'hFFFF_FFFF);
        rd_chk("rd_addr12", 4'd12, 32'd0);
        wr(ADDR_FILT, 32'h0000_0003);
`ifdef GPIO_CTRL_FILTER_EN
        rd_chk("rd_filt", ADDR_FILT, 32'h0000_0003);
`else
        rd_chk("rd_filt_absent", ADDR_FILT, 32'd0);
`endif

        wr(ADDR_IMASK, 32'h0000_0001);
`ifdef GPIO_CTRL_FILTER_EN
        // T=3: two 3-cycle pulses are rejected
        pin[0] = 1'b1; tick(3); pin[0] = 1'b0; tick(3);
        pin[0] = 1'b1; tick(3); pin[0] = 1'b0; tick(10);
        check("glitch_irq", 32'(irq), 32'd0);
        rd_chk("glitch_din", ADDR_DIN, 32'd0);
        rd_chk("glitch_istat", ADDR_ISTAT, 32'd0);
        // Held high: din after 6 cycles, ISTAT after 7, irq after 8
        pin[0] = 1'b1;
        tick(7);
        check("filt_irq_early", 32'(irq), 32'd0);
        tick(1);
        check("filt_irq_rise", 32'(irq), 32'd1);
        rd_chk("filt_din", ADDR_DIN, 32'h0000_0001);
        rd_chk("filt_istat", ADDR_ISTAT, 32'h0000_0001);
        wr(ADDR_ISTAT, 32'h0000_0001);
`else
        // Unfiltered: a 1-cycle pulse reaches din after 2 cycles
        pin[0] = 1'b1; tick(1); pin[0] = 1'b0;
        tick(2);
        check("pulse_irq_early", 32'(irq), 32'd0);
        tick(1);
        check("pulse_irq_rise", 32'(irq), 32'd1);
        rd_chk("pulse_istat", ADDR_ISTAT, 32'h0001_0001);
        rd_chk("pulse_din", ADDR_DIN, 32'd0);
        wr(ADDR_ISTAT, 32'h0001_0001);
        rd_chk("w1c_clear", ADDR_ISTAT, 32'd0);
        check("irq_cleared", 32'(irq), 32'd0);
        pin[0] = 1'b1;
        tick(10);
`endif

        // Fall interrupt through IMASK bit 16
        wr(ADDR_ISTAT, 32'h0001_0001);
        wr(ADDR_IMASK, 32'h0001_0000);
        rd_chk("rd_imask", ADDR_IMASK, 32'h0001_0000);
        check("fall_irq_idle", 32'(irq), 32'd0);
        pin[0] = 1'b0;
        tick(LAT);
        check("fall_irq_early", 32'(irq), 32'd0);
        tick(1);
        check("fall_irq", 32'(irq), 32'd1);

        // W1C of the fall bit committing in the same cycle a new fall is set
        pin[0] = 1'b1;
        tick(12);
        pin[0] = 1'b0;
        tick(LAT - 2);
        wr(ADDR_ISTAT, 32'h0001_0000);
        rd_chk("race_set_wins", ADDR_ISTAT, 32'h0001_0001);
        check("race_irq", 32'(irq), 32'd1);
        wr(ADDR_ISTAT, 32'h0001_0000);
        rd_chk("w1c_fall_only", ADDR_ISTAT, 32'h0000_0001);
        check("rise_masked_irq", 32'(irq), 32'd0);

        // Clearing IE while the pin is high records a fall
        pin[0] = 1'b1;
        tick(12);
        wr(ADDR_ISTAT, 32'h0001_0001);
        wr(ADDR_IE, 32'h0000_0080);
        check("ie_cleared", 32'(pad_ie), 32'h0000_0080);
        tick(12);
        rd_chk("ie_fall", ADDR_ISTAT, 32'h0001_0000);
        check("ie_fall_irq", 32'(irq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
